// File: rtl/dht_fan_pkg.sv
// Shared encodings for the DHT11-driven fan controller: level codes, the
// per-level duty table and the PWM period length.
package dht_fan_pkg;

  typedef enum logic [1:0] {
    LVL_OFF  = 2'd0,
    LVL_LOW  = 2'd1,
    LVL_MID  = 2'd2,
    LVL_HIGH = 2'd3
  } level_t;

  localparam logic [6:0] DUTY_L0 = 7'd0;
  localparam logic [6:0] DUTY_L1 = 7'd40;
  localparam logic [6:0] DUTY_L2 = 7'd70;
  localparam logic [6:0] DUTY_L3 = 7'd100;

  localparam int PWM_STEPS = 100;

  function automatic logic [6:0] level_duty(input level_t lvl);
    logic [6:0] d;
    case (lvl)
      LVL_OFF:  d = DUTY_L0;
      LVL_LOW:  d = DUTY_L1;
      LVL_MID:  d = DUTY_L2;
      default:  d = DUTY_L3;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dht_fan_ctrl_pwm.sv
// 100-step PWM generator; the duty is sampled only at period start so a
// running period is never cut short or stretched.
module pwm_100step
  import dht_fan_pkg::*;
#(
  parameter int PWM_DIV = 1_000
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [6:0] duty,
  output logic       pwm_out
);

  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_DIV - 1);
  localparam logic [6:0]    STEP_LAST  = 7'(PWM_STEPS - 1);

  logic [PW-1:0] presc_q;
  logic [6:0]    step_q;
  logic [6:0]    duty_lat;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      presc_q  <= '0;
      step_q   <= '0;
      duty_lat <= '0;
      pwm_out  <= 1'b0;
    end else begin
      pwm_out <= (step_q < duty_lat);
      if (presc_q == PRESC_LAST) begin
        presc_q <= '0;
        if (step_q == STEP_LAST) begin
          step_q   <= '0;
          duty_lat <= duty;
        end else begin
          step_q <= step_q + 7'd1;
        end
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dht_fan_ctrl.sv
// Fan level selection (hysteresis + dwell filter + humidity boost), duty ramp
// and PWM output, fed by the DHT11 reader's temperature/humidity bytes.
module dht_fan_ctrl
  import dht_fan_pkg::*;
#(
  parameter int T1        = 25,
  parameter int T2        = 28,
  parameter int T3        = 31,
  parameter int HYST      = 1,
  parameter int H_BOOST   = 80,
  parameter int DWELL_CYC = 100_000_000,
  parameter int RAMP_DIV  = 1_000_000,
  parameter int PWM_DIV   = 1_000
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [7:0] temperature,
  input  logic [7:0] humidity,
  input  logic       auto_en,
  input  logic [1:0] manual_level,
  output logic [1:0] fan_level,
  output logic [6:0] duty,
  output logic       pwm_out,
  output logic [3:0] led_bar
);

  localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
  localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_DIV - 1);
  localparam logic [8:0] TH1   = 9'(T1);
  localparam logic [8:0] TH2   = 9'(T2);
  localparam logic [8:0] TH3   = 9'(T3);
  localparam logic [8:0] HYST9 = 9'(HYST);
  localparam logic [7:0] HB    = 8'(H_BOOST);

  logic [7:0]    temp_q, hum_q;
  level_t        level_q, level_d, cand_q, cand_d;
  level_t        up_lvl, down_lvl, target;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [RW-1:0] ramp_q;
  logic [6:0]    duty_q, duty_goal;
  logic [8:0]    temp9, temp_hyst;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      temp_q <= '0;
      hum_q  <= '0;
    end else begin
      temp_q <= temperature;
      hum_q  <= humidity;
    end
  end

  // temp + HYST < Tn is the overflow-free form of temp < Tn - HYST
  always_comb begin
    temp9     = {1'b0, temp_q};
    temp_hyst = temp9 + HYST9;
    up_lvl    = LVL_OFF;
    if (temp9 >= TH1) up_lvl = LVL_LOW;
    if (temp9 >= TH2) up_lvl = LVL_MID;
    if (temp9 >= TH3) up_lvl = LVL_HIGH;
    down_lvl = level_q;
    if (down_lvl == LVL_HIGH && temp_hyst < TH3) down_lvl = LVL_MID;
    if (down_lvl == LVL_MID  && temp_hyst < TH2) down_lvl = LVL_LOW;
    if (down_lvl == LVL_LOW  && temp_hyst < TH1) down_lvl = LVL_OFF;
    target = (up_lvl > level_q) ? up_lvl : down_lvl;
    if (hum_q >= HB && target == LVL_OFF) target = LVL_LOW;
    if (temp_q == 8'd0 && hum_q == 8'd0) target = LVL_OFF;
  end

  always_comb begin
    level_d = level_q;
    cand_d  = cand_q;
    dwell_d = '0;
    if (!auto_en) begin
      level_d = level_t'(manual_level);
      cand_d  = level_t'(manual_level);
    end else if (target != cand_q) begin
      cand_d = target;
    end else if (cand_q != level_q) begin
      if (dwell_q == DWELL_LAST) level_d = cand_q;
      else                       dwell_d = dwell_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      level_q <= LVL_OFF;
      cand_q  <= LVL_OFF;
      dwell_q <= '0;
    end else begin
      level_q <= level_d;
      cand_q  <= cand_d;
      dwell_q <= dwell_d;
    end
  end

  assign duty_goal = level_duty(level_q);

  always_ff @(posedge clk) begin
    if (reset_p) begin
      ramp_q <= '0;
      duty_q <= '0;
    end else if (ramp_q == RAMP_LAST) begin
      ramp_q <= '0;
      if (duty_q < duty_goal)      duty_q <= duty_q + 7'd1;
      else if (duty_q > duty_goal) duty_q <= duty_q - 7'd1;
    end else begin
      ramp_q <= ramp_q + 1'b1;
    end
  end

  pwm_100step #(.PWM_DIV(PWM_DIV)) u_pwm (
    .clk     (clk),
    .reset_p (reset_p),
    .duty    (duty_q),
    .pwm_out (pwm_out)
  );

  assign fan_level = level_q;
  assign duty      = duty_q;
  assign led_bar   = 4'b0001 << level_q;

endmodule

// File: tb/tb_dht_fan_ctrl.sv
// Directed bench for dht_fan_ctrl with short dwell/ramp/PWM dividers so whole
// level changes and PWM periods fit in a few hundred cycles.
module tb_dht_fan_ctrl;

  logic       clk = 1'b0;
  logic       reset_p;
  logic [7:0] temperature, humidity;
  logic       auto_en;
  logic [1:0] manual_level;
  logic [1:0] fan_level;
  logic [6:0] duty;
  logic       pwm_out;
  logic [3:0] led_bar;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] temp;
    logic [7:0] hum;
    logic [1:0] exp_level;
    logic [3:0] exp_led;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  dht_fan_ctrl #(
    .DWELL_CYC (4),
    .RAMP_DIV  (2),
    .PWM_DIV   (1)
  ) dut (
    .clk          (clk),
    .reset_p      (reset_p),
    .temperature  (temperature),
    .humidity     (humidity),
    .auto_en      (auto_en),
    .manual_level (manual_level),
    .fan_level    (fan_level),
    .duty         (duty),
    .pwm_out      (pwm_out),
    .led_bar      (led_bar)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] t, input logic [7:0] h,
                                input logic a, input logic [1:0] m);
    temperature  = t;
    humidity     = h;
    auto_en      = a;
    manual_level = m;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_fan_level"}, fan_level, 0);
    check_output({tag, "_duty"}, duty, 0);
    check_output({tag, "_pwm_out"}, pwm_out, 0);
    check_output({tag, "_led_bar"}, led_bar, 4'b0001);
  endtask

  // duty must move at most 1 per cycle and never leave the start..goal span
  task automatic wait_duty(input int goal, input int limit,
                           output int cycles, output bit smooth);
    int prev, lo, hi;
    prev   = int'(duty);
    lo     = (prev < goal) ? prev : goal;
    hi     = (prev < goal) ? goal : prev;
    cycles = 0;
    smooth = 1'b1;
    while (int'(duty) != goal && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (int'(duty) > prev + 1 || int'(duty) < prev - 1) smooth = 1'b0;
      if (int'(duty) < lo || int'(duty) > hi) smooth = 1'b0;
      prev = int'(duty);
    end
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out === 1'b1) hi++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  cyc, hi, bad;
    bit  smooth;

    vecs[0]  = '{8'd0,  8'd0,  2'd0, 4'b0001};
    vecs[1]  = '{8'd24, 8'd50, 2'd0, 4'b0001};
    vecs[2]  = '{8'd25, 8'd50, 2'd1, 4'b0010};
    vecs[3]  = '{8'd24, 8'd50, 2'd1, 4'b0010};
    vecs[4]  = '{8'd23, 8'd50, 2'd0, 4'b0001};
    vecs[5]  = '{8'd23, 8'd80, 2'd1, 4'b0010};
    vecs[6]  = '{8'd23, 8'd79, 2'd0, 4'b0001};
    vecs[7]  = '{8'd28, 8'd50, 2'd2, 4'b0100};
    vecs[8]  = '{8'd31, 8'd50, 2'd3, 4'b1000};
    vecs[9]  = '{8'd30, 8'd50, 2'd3, 4'b1000};
    vecs[10] = '{8'd29, 8'd50, 2'd2, 4'b0100};
    vecs[11] = '{8'd22, 8'd50, 2'd0, 4'b0001};
    vecs[12] = '{8'd40, 8'd90, 2'd3, 4'b1000};
    vecs[13] = '{8'd0,  8'd0,  2'd0, 4'b0001};
    vecs[14] = '{8'd0,  8'd85, 2'd1, 4'b0010};
    vecs[15] = '{8'd27, 8'd50, 2'd1, 4'b0010};

    reset_p = 1'b1;
    apply_stimulus(8'd0, 8'd0, 1'b1, 2'd0);
    wait_cycles(3);
    check_reset_outputs("reset");
    reset_p = 1'b0;

    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (fan_level !== 2'd0 || duty !== 7'd0 || pwm_out !== 1'b0 ||
          led_bar !== 4'b0001) bad++;
    end
    check_output("idle_hold_bad_cycles", bad, 0);

    apply_stimulus(8'd29, 8'd50, 1'b1, 2'd0);
    wait_cycles(5);
    check_output("dwell_not_yet_level", fan_level, 0);
    wait_cycles(1);
    check_output("dwell_commit_level2", fan_level, 2);
    check_output("dwell_commit_led", led_bar, 4'b0100);
    wait_duty(70, 200, cyc, smooth);
    check_output("ramp_up_duty70", duty, 70);
    check_output("ramp_up_smooth", smooth, 1);
    check_output("ramp_up_rate_ok", (cyc >= 139 && cyc <= 140), 1);
    wait_cycles(200);
    count_high(100, hi);
    check_output("pwm_high_70", hi, 70);

    apply_stimulus(8'd27, 8'd50, 1'b1, 2'd0);
    wait_cycles(20);
    check_output("hyst_hold_level2", fan_level, 2);
    apply_stimulus(8'd26, 8'd50, 1'b1, 2'd0);
    wait_cycles(5);
    check_output("stepdown_not_yet", fan_level, 2);
    wait_cycles(1);
    check_output("stepdown_level1", fan_level, 1);
    wait_duty(40, 100, cyc, smooth);
    check_output("ramp_down_duty40", duty, 40);
    check_output("ramp_down_smooth", smooth, 1);

    bad = 0;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(8'd32, 8'd50, 1'b1, 2'd0);
      repeat (2) begin
        @(negedge clk);
        if (fan_level !== 2'd1) bad++;
      end
      apply_stimulus(8'd25, 8'd50, 1'b1, 2'd0);
      repeat (2) begin
        @(negedge clk);
        if (fan_level !== 2'd1) bad++;
      end
    end
    check_output("dwell_reject_bad_cycles", bad, 0);
    apply_stimulus(8'd32, 8'd50, 1'b1, 2'd0);
    wait_cycles(8);
    check_output("jump_level3", fan_level, 3);
    wait_duty(100, 200, cyc, smooth);
    check_output("ramp_duty100", duty, 100);
    wait_cycles(110);
    count_high(200, hi);
    check_output("pwm_const_high", hi, 200);

    apply_stimulus(8'd20, 8'd85, 1'b1, 2'd0);
    wait_cycles(10);
    check_output("boost_level1", fan_level, 1);
    check_output("boost_led", led_bar, 4'b0010);
    apply_stimulus(8'd20, 8'd85, 1'b0, 2'd3);
    wait_cycles(1);
    check_output("manual_level3_next", fan_level, 3);
    check_output("manual_led", led_bar, 4'b1000);
    wait_duty(100, 300, cyc, smooth);
    check_output("manual_duty100", duty, 100);

    apply_stimulus(8'd20, 8'd85, 1'b0, 2'd1);
    wait_duty(55, 200, cyc, smooth);
    check_output("reach_duty55", duty, 55);
    reset_p = 1'b1;
    manual_level = 2'd3;
    wait_cycles(1);
    check_reset_outputs("midramp_reset");
    reset_p = 1'b0;
    bad = 0;
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      if (k == 1) check_output("post_reset_manual3", fan_level, 3);
      if (k <= 100 && pwm_out !== 1'b0) bad++;
      if (k == 101) check_output("first_period_pwm_high", pwm_out, 1);
    end
    check_output("first_period_low_cycles_bad", bad, 0);

    reset_p = 1'b1;
    apply_stimulus(8'd0, 8'd0, 1'b1, 2'd0);
    wait_cycles(2);
    reset_p = 1'b0;
    for (int v = 0; v < 16; v++) begin
      apply_stimulus(vecs[v].temp, vecs[v].hum, 1'b1, 2'd0);
      wait_cycles(10);
      check_output($sformatf("vec%0d_level", v), fan_level, vecs[v].exp_level);
      check_output($sformatf("vec%0d_led", v), led_bar, vecs[v].exp_led);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
